rand_fetch: RTL and testbench

Initiator side of the random-generator fetch/ack handshake. Issues single-cycle `fetch` pulses to the 28-bit LFSR generator, captures `dir_X` on `ack`, and buffers the words in a small FIFO. Downstream consumers (direction/motion logic) pull words through a valid/ready port. Requests are suppressed while the generator is being seeded and are bounded by a timeout.

---
 rtl/rand_fetch.sv | 145 ++++++++++++++
 tb/tb_rand_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_fetch.sv
// Fetch/ack initiator for the LFSR random generator, buffering words in a small FIFO.
// Optional RAND_DUP_REJECT_EN discards a captured word equal to the last pushed one.
module rand_fetch #(
    parameter int W       = 28,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     seeding,
    output logic                     fetch,
    input  logic                     ack,
    input  logic [W-1:0]             dir_X,
    output logic                     rnd_valid,
    input  logic                     rnd_ready,
    output logic [W-1:0]             rnd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     timeout_err
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     ONE_LEVEL  = (AW+1)'(1);
    localparam logic [7:0]      WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     wait_cnt;
    logic           capture;
    logic           expire;
    logic           push;
    logic           pop;
    logic           dup_err;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW-1:0]  rptr_nxt;
    logic           empty_after_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        fetch     = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!seeding && (level < FULL_LEVEL)) state_nxt = S_REQ;
            end
            S_REQ: begin
                fetch     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ack) begin
                    capture   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else if (state == S_REQ) begin
            wait_cnt <= 8'd0;
        end else if ((state == S_WAIT) && !ack && !expire) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

`ifdef RAND_DUP_REJECT_EN
    logic [W-1:0]   last_word;
    logic [1:0]     dup_cnt;
    logic           dup;

    // A repeated word usually means the LFSR has locked up; drop it and ask again.
    assign dup     = capture && (dir_X == last_word);
    assign push    = capture && !dup;
    assign dup_err = dup && (dup_cnt >= 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_word <= '0;
            dup_cnt   <= 2'd0;
        end else if (push) begin
            last_word <= dir_X;
            dup_cnt   <= 2'd0;
        end else if (dup && (dup_cnt != 2'd3)) begin
            dup_cnt   <= dup_cnt + 2'd1;
        end
    end
`else
    assign push    = capture;
    assign dup_err = 1'b0;
`endif

    assign rnd_valid       = (level != '0);
    assign pop             = rnd_valid && rnd_ready;
    assign rptr_nxt        = rptr + AW'(1);
    assign empty_after_pop = (level == '0) || (pop && (level == ONE_LEVEL));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            rnd_data <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr_nxt;
            case ({push, pop})
                2'b10:   level <= level + ONE_LEVEL;
                2'b01:   level <= level - ONE_LEVEL;
                default: level <= level;
            endcase
            // The head register tracks whichever entry will be at the front after this edge.
            if (push && empty_after_pop)      rnd_data <= dir_X;
            else if (pop && !empty_after_pop) rnd_data <= mem[rptr_nxt];
        end
    end

    // NOTE: storage is not reset; only the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dir_X;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  timeout_err <= 1'b0;
        else if (expire || dup_err)  timeout_err <= 1'b1;
    end

endmodule

// File: tb/tb_rand_fetch.sv
// Scoreboard bench for rand_fetch: a generator model feeds acked words into an
// expected-data queue that is popped whenever the consumer takes a word.
module tb_rand_fetch;

    localparam int W       = 28;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          seeding   = 1'b0;
    logic          ack       = 1'b0;
    logic [W-1:0]  dir_X     = '0;
    logic          rnd_ready = 1'b0;
    logic          fetch;
    logic          rnd_valid;
    logic [W-1:0]  rnd_data;
    logic [LW-1:0] level;
    logic          timeout_err;

    rand_fetch #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .seeding     (seeding),
        .fetch       (fetch),
        .ack         (ack),
        .dir_X       (dir_X),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .rnd_data    (rnd_data),
        .level       (level),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] sb[$];
    logic [W-1:0] gen_words[$];
    logic [W-1:0] gen_next   = 28'h100;
    logic [W-1:0] gw;
    bit           gen_on     = 1'b1;
    bit           fetch_seen = 1'b0;
    int           cyc        = 0;
    int           fetch_cnt  = 0;
    int           ack_cnt    = 0;
    int           fetch_cyc[$];
`ifdef RAND_DUP_REJECT_EN
    logic [W-1:0] model_last = '0;
`endif

    // Monitor: samples mid-cycle, counts fetch pulses and checks popped words.
    always @(negedge clk) begin
        cyc++;
        fetch_seen = fetch && reset;
        if (reset && fetch) begin
            fetch_cnt++;
            fetch_cyc.push_back(cyc);
        end
        if (reset && rnd_valid && rnd_ready)
            check("pop_data", 32'(rnd_data), (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD_BEEF);
    end

    // Generator: acks one cycle after it samples fetch, word valid with ack.
    always @(posedge clk) begin
        #1;
        if (fetch_seen && gen_on) begin
            if (gen_words.size() != 0) begin
                gw = gen_words.pop_front();
            end else begin
                gw       = gen_next;
                gen_next = gen_next + 28'h1;
            end
            ack   = 1'b1;
            dir_X = gw;
            ack_cnt++;
`ifdef RAND_DUP_REJECT_EN
            if (gw != model_last) begin
                sb.push_back(gw);
                model_last = gw;
            end
`else
            sb.push_back(gw);
`endif
        end else begin
            ack = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fetch"},       32'(fetch),       0);
        check({tag, "_rnd_valid"},   32'(rnd_valid),   0);
        check({tag, "_rnd_data"},    32'(rnd_data),    0);
        check({tag, "_level"},       32'(level),       0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int k;

        // Fill from reset with a fixed word sequence and no consumer.
        gen_words = '{28'h0000001, 28'h0000003, 28'h0000007, 28'h000000F};
        #7;
        check_reset_values("reset");
        @(posedge clk);
        #2 reset = 1'b1;
        tick(30);
        check("fill_fetch_count", 32'(fetch_cnt), 4);
        for (int i = 1; i < fetch_cyc.size(); i++)
            check("fill_fetch_gap", 32'(fetch_cyc[i] - fetch_cyc[i-1]), 3);
        check("fill_level", 32'(level), 4);
        check("fill_valid", 32'(rnd_valid), 1);
        check("fill_head", 32'(rnd_data), 32'h0000001);

        // Single pop from a full FIFO triggers one refill request.
        n0 = fetch_cnt;
        rnd_ready = 1'b1;
        tick(1);
        rnd_ready = 1'b0;
        check("pop_level", 32'(level), 3);
        check("pop_head", 32'(rnd_data), 32'h0000003);
        tick(2);
        check("refill_fetch", 32'(fetch_cnt), 32'(n0 + 1));
        tick(5);
        check("refill_level", 32'(level), 4);
        check("refill_model", 32'(level), 32'(sb.size()));

        // Seeding blocks requests on an empty FIFO.
        seeding = 1'b1;
        tick(3);
        rnd_ready = 1'b1;
        for (k = 0; k < 50 && level != 0; k++) tick(1);
        rnd_ready = 1'b0;
        check("drain_level", 32'(level), 0);
        n0 = fetch_cnt;
        tick(20);
        check("seed_no_fetch", 32'(fetch_cnt), 32'(n0));
        check("seed_level", 32'(level), 0);
        gen_on  = 1'b0;
        seeding = 1'b0;
        check("seed_release_c1", 32'(fetch), 0);
        tick(1);
        check("seed_release_c2", 32'(fetch), 1);

        // No ack: WAIT lasts exactly TIMEOUT cycles, then a new request.
        tick(TIMEOUT);
        check("to_last_wait", 32'(timeout_err), 0);
        tick(1);
        check("to_set", 32'(timeout_err), 1);
        check("to_idle_fetch", 32'(fetch), 0);
        tick(1);
        check("to_rerequest", 32'(fetch), 1);
        gen_on = 1'b1;
        tick(6);
        check("to_sticky", 32'(timeout_err), 1);
        check("to_level_model", 32'(level), 32'(sb.size()));

        // Push and pop on the same edge at level 2.
        for (k = 0; k < 40 && !(level == 2 && ack); k++) tick(1);
        check("pp_setup", 32'(level), 2);
        rnd_ready = 1'b1;
        tick(1);
        rnd_ready = 1'b0;
        check("pp_level", 32'(level), 2);
        check("pp_model", 32'(level), 32'(sb.size()));
        seeding = 1'b1;
        tick(4);
        rnd_ready = 1'b1;
        for (k = 0; k < 50 && level != 0; k++) tick(1);
        rnd_ready = 1'b0;
        check("pp_drained", 32'(sb.size()), 0);

        // Reset asserted in WAIT with a non-empty FIFO.
        seeding = 1'b0;
        for (k = 0; k < 40 && level != 2; k++) tick(1);
        gen_on = 1'b0;
        check("rw_setup", 32'(level), 2);
        for (k = 0; k < 10 && !fetch; k++) tick(1);
        tick(1);
        #1 reset = 1'b0;
        #1 check_reset_values("rst_wait");
        sb.delete();
        tick(2);
        reset  = 1'b1;
        gen_on = 1'b1;

        // Reset asserted during the REQ cycle drops fetch immediately.
        for (k = 0; k < 10 && !fetch; k++) tick(1);
        check("rr_setup", 32'(fetch), 1);
        reset = 1'b0;
        #1 check("rst_req_fetch", 32'(fetch), 0);
        sb.delete();
        tick(1);
        reset = 1'b1;
        tick(12);
        check("post_reset_model", 32'(level), 32'(sb.size()));

`ifdef RAND_DUP_REJECT_EN
        // Repeated all-ones words: one push, then three rejections.
        reset = 1'b0;
        sb.delete();
        model_last = '0;
        gen_words  = '{28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF};
        ack_cnt    = 0;
        tick(1);
        reset = 1'b1;
        for (k = 0; k < 60 && ack_cnt < 4; k++) tick(1);
        check("dup_err_before", 32'(timeout_err), 0);
        tick(1);
        check("dup_err_set", 32'(timeout_err), 1);
        check("dup_level", 32'(level), 1);
        check("dup_head", 32'(rnd_data), 32'h0FFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
